// File: rtl/mp_regfile_pkg.sv
// Shared constants and helpers for the multi-ported register file (package regfile_pkg).
// Optional same-cycle write-to-read bypass is selected by the REGFILE_BYPASS_EN macro.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 32;
  localparam int NRD_DEF    = 2;
  localparam int NWR_DEF    = 2;
  localparam int ZERO_REG   = 0;

  // Widest write-port count the match helper accepts.
  localparam int MAX_WR = 8;

  // Index of the highest set bit in a per-port match vector; 0 if none is set.
  function automatic int hi_match(input logic [MAX_WR-1:0] hits);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_WR; i++) begin
      if (hits[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mp_regfile_if.sv
// Decode/writeback bus of mp_regfile: read ports, write ports, issue and flush.
// Handshake: no valid/ready pairs; we[w] and iss_valid are single-cycle qualifiers sampled at posedge.
interface mp_regfile_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]     raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic [NWR*AW-1:0]     waddr;
  logic [NWR*DATA_W-1:0] wdata;
  logic [NWR-1:0]        we;
  logic                  iss_valid;
  logic [AW-1:0]         iss_addr;
  logic                  flush;

  modport master (
    output raddr, waddr, wdata, we, iss_valid, iss_addr, flush,
    input  rdata, rbusy
  );

  modport slave (
    input  raddr, waddr, wdata, we, iss_valid, iss_addr, flush,
    output rdata, rbusy
  );
endinterface

// File: rtl/mp_regfile_scoreboard.sv
// rf_scoreboard: per-register pending-write bits with flush > issue-set > write-clear priority.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             iss_valid_i,
  input  logic [AW-1:0]    iss_addr_i,
  input  logic             flush_i,
  input  logic [NREGS-1:0] clr_i,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q & ~clr_i;
    if (iss_valid_i && (iss_addr_i != AW'(ZERO_REG))) begin
      busy_d[iss_addr_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/mp_regfile.sv
// Multi-ported architectural register file with decode-interlock scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and clear rbusy) on matching reads.
module mp_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NWR    = NWR_DEF
) (
  input  logic        clk,
  input  logic        rst_b,
  mp_regfile_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [NWR-1:0]    wr_eff;
  logic [NREGS-1:0]  clr_vec;
  logic [NREGS-1:0]  busy;

  always_comb begin
    wr_eff  = '0;
    clr_vec = '0;
    for (int w = 0; w < NWR; w++) begin
      wr_eff[w] = bus.we[w] && (bus.waddr[w*AW +: AW] != AW'(ZERO_REG));
      if (wr_eff[w]) clr_vec[bus.waddr[w*AW +: AW]] = 1'b1;
    end
  end

  // Later ports overwrite earlier ones in the loop, so the highest index wins a conflict.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_eff[w]) mem_q[bus.waddr[w*AW +: AW]] <= bus.wdata[w*DATA_W +: DATA_W];
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk         (clk),
    .rst_b       (rst_b),
    .iss_valid_i (bus.iss_valid),
    .iss_addr_i  (bus.iss_addr),
    .flush_i     (bus.flush),
    .clr_i       (clr_vec),
    .busy_o      (busy)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rd;
    logic              rb;
`ifdef REGFILE_BYPASS_EN
    logic [NWR-1:0]    hits;
    int                hi;
`endif

    always_comb begin
      ra = bus.raddr[p*AW +: AW];
      rd = mem_q[ra];
      rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
      hits = '0;
      for (int w = 0; w < NWR; w++) begin
        hits[w] = wr_eff[w] && (bus.waddr[w*AW +: AW] == ra);
      end
      hi = hi_match(MAX_WR'(hits));
      if (|hits) begin
        rd = bus.wdata[hi*DATA_W +: DATA_W];
        rb = bus.iss_valid && (bus.iss_addr == ra);
      end
`endif
      // Bypassed values must not leak out while reset holds everything at zero.
      if (!rst_b || (ra == AW'(ZERO_REG))) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign bus.rdata[p*DATA_W +: DATA_W] = rd;
    assign bus.rbusy[p]                  = rb;
  end

endmodule

// File: tb/tb_mp_regfile.sv
// Directed self-checking bench for mp_regfile: vector table plus reset/bypass sequences.
module tb_mp_regfile;

  logic clk;
  logic rst_b;
  int   n_tests;
  int   n_fail;

  mp_regfile_if #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2)) rf ();

  mp_regfile #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [4:0]  wa1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        iss;
    logic [4:0]  ia;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ex0;
    logic [31:0] ex1;
    logic [1:0]  exb;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic iss, input logic [4:0] ia, input logic fl);
    rf.we        = we;
    rf.waddr     = {wa1, wa0};
    rf.wdata     = {wd1, wd0};
    rf.iss_valid = iss;
    rf.iss_addr  = ia;
    rf.flush     = fl;
  endtask

  task automatic idle();
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rf.raddr = {a1, a0};
  endtask

  task automatic check_rd(input string name, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [1:0] eb);
    check({name, ".rdata0"}, rf.rdata[31:0], e0);
    check({name, ".rdata1"}, rf.rdata[63:32], e1);
    check({name, ".rbusy"}, {30'h0, rf.rbusy}, {30'h0, eb});
  endtask

  task automatic edge_then_idle();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_b   = 1'b0;
    idle();
    set_rd(5'd3, 5'd0);

    //          we     wa0    wa1    wd0           wd1           iss   ia     fl    ra0    ra1    ex0           ex1           exb
    vecs[0]  = '{2'b01, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 5'd0,  1'b0, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00};
    vecs[1]  = '{2'b01, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd3,  32'h0,        32'hDEADBEEF, 2'b00};
    vecs[2]  = '{2'b11, 5'd7,  5'd7,  32'h11,       32'h22,       1'b0, 5'd0,  1'b0, 5'd7,  5'd3,  32'h22,       32'hDEADBEEF, 2'b00};
    vecs[3]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd7,  32'h0,        32'h22,       2'b01};
    vecs[4]  = '{2'b10, 5'd0,  5'd9,  32'h0,        32'h5,        1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  32'h5,        32'h5,        2'b00};
    vecs[5]  = '{2'b01, 5'd9,  5'd0,  32'h6,        32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd3,  32'h6,        32'hDEADBEEF, 2'b01};
    vecs[6]  = '{2'b11, 5'd12, 5'd9,  32'hAB,       32'h7,        1'b0, 5'd0,  1'b0, 5'd12, 5'd9,  32'hAB,       32'h7,        2'b00};
    vecs[7]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd2,  1'b0, 5'd2,  5'd0,  32'h0,        32'h0,        2'b01};
    vecs[8]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd4,  1'b0, 5'd4,  5'd2,  32'h0,        32'h0,        2'b11};
    vecs[9]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd6,  1'b0, 5'd6,  5'd4,  32'h0,        32'h0,        2'b11};
    vecs[10] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd8,  1'b1, 5'd8,  5'd2,  32'h0,        32'h0,        2'b00};
    vecs[11] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  1'b0, 5'd4,  5'd6,  32'h0,        32'h0,        2'b00};
    vecs[12] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00};
    vecs[13] = '{2'b11, 5'd20, 5'd0,  32'h1,        32'h55,       1'b0, 5'd0,  1'b0, 5'd20, 5'd0,  32'h1,        32'h0,        2'b00};

    repeat (3) @(posedge clk);
    #1;
    check_rd("reset_init", 32'h0, 32'h0, 2'b00);
    rst_b = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].we, vecs[i].wa0, vecs[i].wa1, vecs[i].wd0, vecs[i].wd1,
            vecs[i].iss, vecs[i].ia, vecs[i].fl);
      edge_then_idle();
      set_rd(vecs[i].ra0, vecs[i].ra1);
      #1;
      check_rd($sformatf("vec%0d", i), vecs[i].ex0, vecs[i].ex1, vecs[i].exb);
    end

    // Bypass: r10 holds 0xBEEF and is busy, then written with 0xCAFE while being read.
    drive(2'b01, 5'd10, 5'd0, 32'hBEEF, 32'h0, 1'b1, 5'd10, 1'b0);
    edge_then_idle();
    drive(2'b01, 5'd10, 5'd0, 32'hCAFE, 32'h0, 1'b0, 5'd0, 1'b0);
    set_rd(5'd10, 5'd10);
    #1;
`ifdef REGFILE_BYPASS_EN
    check_rd("bypass_same_cycle", 32'hCAFE, 32'hCAFE, 2'b00);
`else
    check_rd("bypass_same_cycle", 32'hBEEF, 32'hBEEF, 2'b11);
`endif
    edge_then_idle();
    #1;
    check_rd("bypass_after_edge", 32'hCAFE, 32'hCAFE, 2'b00);

    // Issue and write of the same register in one cycle: issue keeps it busy.
    drive(2'b01, 5'd10, 5'd0, 32'hF00D, 32'h0, 1'b1, 5'd10, 1'b0);
    #1;
`ifdef REGFILE_BYPASS_EN
    check_rd("bypass_iss_same", 32'hF00D, 32'hF00D, 2'b11);
`else
    check_rd("bypass_iss_same", 32'hCAFE, 32'hCAFE, 2'b00);
`endif
    edge_then_idle();
    #1;
    check_rd("bypass_iss_after", 32'hF00D, 32'hF00D, 2'b11);

    // Mid-run reset clears storage and scoreboard immediately and discards writes.
    drive(2'b01, 5'd5, 5'd0, 32'h1234, 32'h0, 1'b1, 5'd5, 1'b0);
    edge_then_idle();
    set_rd(5'd5, 5'd3);
    #1;
    check_rd("pre_reset", 32'h1234, 32'hDEADBEEF, 2'b01);
    rst_b = 1'b0;
    #1;
    check_rd("in_reset", 32'h0, 32'h0, 2'b00);
    drive(2'b01, 5'd5, 5'd0, 32'h9999, 32'h0, 1'b1, 5'd5, 1'b0);
    edge_then_idle();
    rst_b = 1'b1;
    #1;
    check_rd("reset_release", 32'h0, 32'h0, 2'b00);
    drive(2'b10, 5'd0, 5'd5, 32'h0, 32'h77, 1'b0, 5'd0, 1'b0);
    edge_then_idle();
    #1;
    check_rd("post_reset_write", 32'h77, 32'h0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
